// File: rtl/player_sprite_pixel_pipe_if.sv
// Player sprite pixel pipe bus: raster position, generator outputs, sprite ROM
// port and the registered player pixel for the colour mapper.
//   master : upstream / ROM side, drives raster, generator and ROM data signals
//   slave  : the pixel pipe, drives rom_addr and the pixel outputs
//   DrawX, DrawY   raster position
//   src_on         playerOn per generator
//   src_addr       spriteAddress per generator, src k at [k*ADDR_W +: ADDR_W]
//   anim_sel       requested generator (sampled at frame start)
//   invincible     blink enable
//   rom_addr       sprite ROM read address
//   rom_data       sprite ROM colour index
//   pix_on/pix_idx player pixel flag and colour index
//   pix_x/pix_y    raster position aligned with pix_on
//   active_sel     generator in use this frame
interface player_sprite_pixel_pipe_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ADDR_W  = 21,
    parameter int unsigned IDX_W   = 4
);
    logic [9:0]                DrawX;
    logic [9:0]                DrawY;
    logic [NUM_SRC-1:0]        src_on;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [1:0]                anim_sel;
    logic                      invincible;
    logic [ADDR_W-1:0]         rom_addr;
    logic [IDX_W-1:0]          rom_data;
    logic                      pix_on;
    logic [IDX_W-1:0]          pix_idx;
    logic [9:0]                pix_x;
    logic [9:0]                pix_y;
    logic [1:0]                active_sel;

    modport master (
        output DrawX, DrawY, src_on, src_addr, anim_sel, invincible, rom_data,
        input  rom_addr, pix_on, pix_idx, pix_x, pix_y, active_sel
    );

    modport slave (
        input  DrawX, DrawY, src_on, src_addr, anim_sel, invincible, rom_data,
        output rom_addr, pix_on, pix_idx, pix_x, pix_y, active_sel
    );
endinterface

// File: rtl/player_sprite_pixel_pipe.sv
// Player sprite pixel pipe: picks one animation generator per frame, issues the
// sprite ROM read, applies transparency (index 0) and invincibility blinking,
// and emits a registered player pixel with aligned raster coordinates.
// Latency from raster input to pix_on is ROM_LAT+2 clocks, one pixel per clock.
// Ports:
//   Clk    pixel clock
//   Reset  asynchronous, active-high
//   bus    player_sprite_pixel_pipe_if slave (raster, generators, ROM, pixel out)
module player_sprite_pixel_pipe #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned ROM_LAT      = 1,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    player_sprite_pixel_pipe_if.slave   bus
);

    localparam int unsigned XY_W  = 10;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam int unsigned HALF  = BLINK_PERIOD / 2;

    logic                           frameStart_c;
    logic                           blank_c;
    logic                           selOn_c;
    logic [ADDR_W-1:0]              selAddr_c;
    logic                           pixOnNext_c;

    logic [SEL_W-1:0]               activeSel;
    logic [SEL_W-1:0]               activeSelNext;
    logic [CNT_W-1:0]               frameCnt;
    logic [CNT_W-1:0]               frameCntNext;
    logic [ADDR_W-1:0]              romAddr;
    logic [ADDR_W-1:0]              romAddrNext;

    logic                           onA;
    logic [XY_W-1:0]                xA;
    logic [XY_W-1:0]                yA;

    logic [ROM_LAT-1:0]             onPipe;
    logic [ROM_LAT-1:0][XY_W-1:0]   xPipe;
    logic [ROM_LAT-1:0][XY_W-1:0]   yPipe;
    logic [ROM_LAT-1:0]             onPipeNext_c;
    logic [ROM_LAT-1:0][XY_W-1:0]   xPipeNext_c;
    logic [ROM_LAT-1:0][XY_W-1:0]   yPipeNext_c;

    logic                           pixOn;
    logic [IDX_W-1:0]               pixIdx;
    logic [XY_W-1:0]                pixX;
    logic [XY_W-1:0]                pixY;

    assign frameStart_c = (bus.DrawX == '0) && (bus.DrawY == '0);

    // Blank during the second half of the blink period; the live invincible
    // input gates it so dropping invincibility unblanks on the very next pixel.
    assign blank_c = bus.invincible && (frameCnt >= CNT_W'(HALF));

    // Generator mux driven by the registered selection
    always_comb begin
        selOn_c   = 1'b0;
        selAddr_c = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (activeSel == SEL_W'(k)) begin
                selOn_c   = bus.src_on[k];
                selAddr_c = bus.src_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state for selection, blink counter and ROM address
    always_comb begin
        activeSelNext = activeSel;
        frameCntNext  = frameCnt;
        romAddrNext   = romAddr;
        pixOnNext_c   = onPipe[ROM_LAT-1] && (bus.rom_data != '0);

        // Out-of-range requests keep the current generator
        if (frameStart_c && (32'(bus.anim_sel) < NUM_SRC)) begin
            activeSelNext = bus.anim_sel;
        end

        if (!bus.invincible) begin
            frameCntNext = '0;
        end else if (frameStart_c) begin
            frameCntNext = (frameCnt == CNT_W'(BLINK_PERIOD - 1)) ? '0 : frameCnt + CNT_W'(1);
        end

        // Hold the last address while the sprite is off to avoid needless ROM toggling
        if (selOn_c) begin
            romAddrNext = selAddr_c;
        end
    end

    // Delay line that keeps the on flag and coordinates in step with rom_data
    generate
        if (ROM_LAT == 1) begin : g_lat1
            assign onPipeNext_c = onA;
            assign xPipeNext_c  = xA;
            assign yPipeNext_c  = yA;
        end else begin : g_latN
            assign onPipeNext_c = {onPipe[ROM_LAT-2:0], onA};
            assign xPipeNext_c  = {xPipe[ROM_LAT-2:0], xA};
            assign yPipeNext_c  = {yPipe[ROM_LAT-2:0], yA};
        end
    endgenerate

    // Pipeline registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            activeSel <= '0;
            frameCnt  <= '0;
            romAddr   <= '0;
            onA       <= 1'b0;
            xA        <= '0;
            yA        <= '0;
            onPipe    <= '0;
            xPipe     <= '0;
            yPipe     <= '0;
            pixOn     <= 1'b0;
            pixIdx    <= '0;
            pixX      <= '0;
            pixY      <= '0;
        end else begin
            activeSel <= activeSelNext;
            frameCnt  <= frameCntNext;
            romAddr   <= romAddrNext;
            onA       <= selOn_c & ~blank_c;
            xA        <= bus.DrawX;
            yA        <= bus.DrawY;
            onPipe    <= onPipeNext_c;
            xPipe     <= xPipeNext_c;
            yPipe     <= yPipeNext_c;
            pixOn     <= pixOnNext_c;
            pixIdx    <= pixOnNext_c ? bus.rom_data : '0;
            pixX      <= xPipe[ROM_LAT-1];
            pixY      <= yPipe[ROM_LAT-1];
        end
    end

    assign bus.rom_addr   = romAddr;
    assign bus.pix_on     = pixOn;
    assign bus.pix_idx    = pixIdx;
    assign bus.pix_x      = pixX;
    assign bus.pix_y      = pixY;
    assign bus.active_sel = activeSel;

endmodule
